// File: rtl/adc_frame_align.sv
// adc_frame_align: frame-alignment controller for the ADC LVDS receive path.
// Watches the deserialized 14-bit frame-clock word and issues one-cycle
// bitslip pulses to the deserializers until the word equals FRAME_PATTERN,
// then holds lock (FrmAlignDone) for the data-capture blocks.
//
// Optional feature: define ADC_FRAME_ALIGN_MONITOR_EN to build loss-of-lock
// monitoring. Without it, LOCKED is sticky and FrmData is ignored once locked.
//
// Single clock domain (FrmClkDiv), synchronous active-low reset (FrmRstN).

module adc_frame_align #(
    parameter logic [13:0] FRAME_PATTERN = 14'b11111110000000,
    parameter int unsigned SLIP_WAIT     = 4,   // settle cycles after a bitslip (1..15)
    parameter int unsigned MATCH_COUNT   = 8,   // consecutive matches to lock (1..255)
    parameter int unsigned LOSS_COUNT    = 4    // consecutive mismatches to unlock (1..255)
) (
    input  logic        FrmClkDiv,
    input  logic        FrmRstN,
    input  logic [13:0] FrmData,
    input  logic        AlignStart,
    output logic        FrmBitslip,
    output logic        FrmAlignDone,
    output logic        FrmAlignErr,
    output logic [3:0]  SlipCount
);

    // Alignment controller states.
    typedef enum logic [2:0] {
        ST_CHECK  = 3'd0,
        ST_SLIP   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    // Terminal counter values; comparing against "last" keeps every counter
    // bounded, so none of them can wrap.
    localparam logic [3:0] SLIP_LAST  = 4'd13;
    localparam logic [3:0] WAIT_LAST  = 4'(SLIP_WAIT - 1);
    localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
    localparam logic [7:0] LOSS_LAST  = 8'(LOSS_COUNT - 1);
`endif

    state_e     state_q,     state_d;
    logic [3:0] slip_cnt_q,  slip_cnt_d;
    logic [3:0] wait_cnt_q,  wait_cnt_d;
    logic [7:0] match_cnt_q, match_cnt_d;
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
    logic [7:0] loss_cnt_q,  loss_cnt_d;
`endif
    logic       bitslip_q,   bitslip_d;
    logic       done_q,      done_d;
    logic       err_q,       err_d;

    logic       frame_match;

    assign frame_match = (FrmData == FRAME_PATTERN);

    // Next-state and counter logic; AlignStart overrides all state behaviour.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        slip_cnt_d  = slip_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        match_cnt_d = match_cnt_q;
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
        loss_cnt_d  = loss_cnt_q;
`endif

        if (AlignStart) begin
            state_d     = ST_CHECK;
            slip_cnt_d  = '0;
            wait_cnt_d  = '0;
            match_cnt_d = '0;
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
            loss_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_CHECK: begin
                    if (frame_match) begin
                        if (match_cnt_q >= MATCH_LAST) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 8'd1;
                        end
                    end else begin
                        match_cnt_d = '0;
                        if (slip_cnt_q >= SLIP_LAST) begin
                            // Every slip position has been tried.
                            state_d = ST_FAIL;
                        end else begin
                            // SlipCount advances together with the pulse.
                            state_d    = ST_SLIP;
                            slip_cnt_d = slip_cnt_q + 4'd1;
                        end
                    end
                end

                ST_SLIP: begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end

                ST_WAIT: begin
                    // Deserializer output is unstable right after a slip.
                    if (wait_cnt_q >= WAIT_LAST) begin
                        state_d    = ST_CHECK;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end

                ST_LOCKED: begin
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
                    if (frame_match) begin
                        loss_cnt_d = '0;
                    end else if (loss_cnt_q >= LOSS_LAST) begin
                        // Lock lost: restart the search from slip position 0.
                        state_d     = ST_CHECK;
                        loss_cnt_d  = '0;
                        slip_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
`else
                    // Sticky lock: only AlignStart or reset leaves this state.
                    state_d = ST_LOCKED;
`endif
                end

                ST_FAIL: begin
                    state_d = ST_FAIL;
                end

                default: begin
                    state_d = ST_CHECK;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear registered,
    // aligned with the state they describe.
    always_comb begin
        bitslip_d = (state_d == ST_SLIP);
        done_d    = (state_d == ST_LOCKED);
        err_d     = (state_d == ST_FAIL);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge FrmClkDiv) begin
        // NOTE: all control registers, counters included, are reset so that
        // alignment always restarts from slip position 0 with no stray pulse.
        if (!FrmRstN) begin
            state_q     <= ST_CHECK;
            slip_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            match_cnt_q <= '0;
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
            loss_cnt_q  <= '0;
`endif
            bitslip_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            slip_cnt_q  <= slip_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            match_cnt_q <= match_cnt_d;
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
            loss_cnt_q  <= loss_cnt_d;
`endif
            bitslip_q   <= bitslip_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign FrmBitslip   = bitslip_q;
    assign FrmAlignDone = done_q;
    assign FrmAlignErr  = err_q;
    assign SlipCount    = slip_cnt_q;

endmodule

// File: tb/tb_adc_frame_align.sv
// tb_adc_frame_align: self-checking bench for adc_frame_align.
// Expected timing comes from closed-form arithmetic on the alignment rules
// (pulse spacing SLIP_WAIT+2, lock after MATCH_COUNT matches, loss after
// LOSS_COUNT consecutive mismatches). A frame model rotates the pattern one
// bit per observed bitslip. Loss-of-lock expectations follow the build's
// ADC_FRAME_ALIGN_MONITOR_EN setting.

module tb_adc_frame_align;

    localparam logic [13:0] PAT = 14'b11111110000000;
    localparam int W    = 4;
    localparam int M    = 8;
    localparam int LOSS = 4;

    localparam int DM_MODEL = 0;  // rotated pattern from the frame model
    localparam int DM_NOISE = 1;  // random words that never equal the pattern
    localparam int DM_FIXED = 2;  // drv_data as set by the scenario

    logic        clk = 1'b0;
    logic        FrmRstN = 1'b0;
    logic        AlignStart = 1'b0;
    logic [13:0] FrmData = '0;
    logic        FrmBitslip;
    logic        FrmAlignDone;
    logic        FrmAlignErr;
    logic [3:0]  SlipCount;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int offset = 0;
    int data_mode = DM_NOISE;
    logic [13:0] drv_data = '0;
    logic rst_n_req = 1'b0;
    logic start_req = 1'b0;

    logic       obs_slip, obs_done, obs_err;
    logic [3:0] obs_cnt;

    adc_frame_align #(
        .FRAME_PATTERN(PAT),
        .SLIP_WAIT    (W),
        .MATCH_COUNT  (M),
        .LOSS_COUNT   (LOSS)
    ) dut (
        .FrmClkDiv   (clk),
        .FrmRstN     (FrmRstN),
        .FrmData     (FrmData),
        .AlignStart  (AlignStart),
        .FrmBitslip  (FrmBitslip),
        .FrmAlignDone(FrmAlignDone),
        .FrmAlignErr (FrmAlignErr),
        .SlipCount   (SlipCount)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] rotl(input logic [13:0] v, input int n);
        logic [13:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[12:0], r[13]};
        return r;
    endfunction

    function automatic logic [13:0] noise_word();
        logic [13:0] w;
        do w = 14'($urandom); while (w == PAT);
        return w;
    endfunction

    // One cycle: observe outputs at the falling edge, update the frame model,
    // then drive this cycle's inputs (sampled at the next rising edge).
    task automatic step();
        @(negedge clk);
        cyc++;
        obs_slip = FrmBitslip;
        obs_done = FrmAlignDone;
        obs_err  = FrmAlignErr;
        obs_cnt  = SlipCount;
        if (obs_slip === 1'b1) offset = (offset + 13) % 14;
        FrmRstN    = rst_n_req;
        AlignStart = start_req;
        case (data_mode)
            DM_MODEL: FrmData = rotl(PAT, offset);
            DM_NOISE: FrmData = noise_word();
            default:  FrmData = drv_data;
        endcase
    endtask

    task automatic do_reset();
        rst_n_req = 1'b0;
        step();
        rst_n_req = 1'b1;
    endtask

    // Run until lock; s0 is the first cycle sampled in CHECK.
    task automatic run_align(input int k, input int s0, input string tag);
        int pulse_at[$];
        int done_at;
        int exp_done;
        done_at = -1;
        for (int n = 0; n < 1000 && done_at < 0; n++) begin
            step();
            if (obs_slip === 1'b1) begin
                pulse_at.push_back(cyc);
                checks++;
                if (obs_cnt !== 4'(pulse_at.size())) begin
                    errors++;
                    $display("FAIL %s slipcount_at_pulse%0d: got %0d expected %0d",
                             tag, pulse_at.size(), obs_cnt, pulse_at.size());
                end
            end
            if (obs_done === 1'b1) done_at = cyc;
        end
        exp_done = s0 + k * (W + 2) + M;
        checks++;
        if (done_at != exp_done) begin
            errors++;
            $display("FAIL %s done_rise: got cycle %0d expected %0d (-1 = never)", tag, done_at, exp_done);
        end
        checks++;
        if (pulse_at.size() != k) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d expected %0d", tag, pulse_at.size(), k);
        end
        for (int i = 0; i < pulse_at.size() && i < k; i++) begin
            checks++;
            if (pulse_at[i] != s0 + 1 + i * (W + 2)) begin
                errors++;
                $display("FAIL %s pulse%0d_time: got cycle %0d expected %0d",
                         tag, i, pulse_at[i], s0 + 1 + i * (W + 2));
            end
        end
        checks++;
        if (obs_cnt !== 4'(k)) begin
            errors++;
            $display("FAIL %s slipcount_locked: got %0d expected %0d", tag, obs_cnt, k);
        end
        checks++;
        if (obs_err !== 1'b0) begin
            errors++;
            $display("FAIL %s err_locked: got %b expected 0", tag, obs_err);
        end
    endtask

    task automatic test_reset();
        rst_n_req = 1'b0;
        data_mode = DM_NOISE;
        step();
        step();
        checks++;
        if ({obs_slip, obs_done, obs_err, obs_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL reset_values: got slip=%b done=%b err=%b cnt=%0d expected all 0",
                     obs_slip, obs_done, obs_err, obs_cnt);
        end
        rst_n_req = 1'b1;
    endtask

    task automatic test_align();
        int ks[$];
        ks = '{5, 0, 13};
        repeat (3) ks.push_back(int'($urandom_range(1, 12)));
        foreach (ks[i]) begin
            do_reset();
            offset = ks[i];
            data_mode = DM_MODEL;
            run_align(ks[i], cyc + 1, $sformatf("align_k%0d", ks[i]));
        end
    endtask

    task automatic test_fail();
        int pulse_at[$];
        int err_at;
        int s0;
        int extra_pulses;
        int err_drops;
        do_reset();
        data_mode = DM_NOISE;
        s0 = cyc + 1;
        err_at = -1;
        for (int n = 0; n < 1000 && err_at < 0; n++) begin
            step();
            if (obs_slip === 1'b1) pulse_at.push_back(cyc);
            if (obs_err === 1'b1) err_at = cyc;
        end
        checks++;
        if (pulse_at.size() != 13) begin
            errors++;
            $display("FAIL fail_pulse_count: got %0d expected 13", pulse_at.size());
        end
        for (int i = 0; i < pulse_at.size() && i < 13; i++) begin
            checks++;
            if (pulse_at[i] != s0 + 1 + i * (W + 2)) begin
                errors++;
                $display("FAIL fail_pulse%0d_time: got cycle %0d expected %0d",
                         i, pulse_at[i], s0 + 1 + i * (W + 2));
            end
        end
        checks++;
        if (err_at != s0 + 13 * (W + 2) + 1) begin
            errors++;
            $display("FAIL fail_err_rise: got cycle %0d expected %0d (-1 = never)",
                     err_at, s0 + 13 * (W + 2) + 1);
        end
        checks++;
        if (obs_cnt !== 4'd13) begin
            errors++;
            $display("FAIL fail_slipcount: got %0d expected 13", obs_cnt);
        end
        extra_pulses = 0;
        err_drops = 0;
        repeat (100) begin
            step();
            if (obs_slip !== 1'b0) extra_pulses++;
            if (obs_err !== 1'b1 || obs_done !== 1'b0) err_drops++;
        end
        checks++;
        if (extra_pulses != 0) begin
            errors++;
            $display("FAIL fail_quiet: got %0d pulses expected 0", extra_pulses);
        end
        checks++;
        if (err_drops != 0) begin
            errors++;
            $display("FAIL fail_hold: got %0d cycles with err!=1 or done!=0 expected 0", err_drops);
        end
        // AlignStart out of FAIL; data keeps mismatching.
        start_req = 1'b1;
        step();                       // cycle A
        start_req = 1'b0;
        step();                       // A+1
        checks++;
        if ({obs_err, obs_done, obs_slip, obs_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL fail_restart_clear: got err=%b done=%b slip=%b cnt=%0d expected all 0",
                     obs_err, obs_done, obs_slip, obs_cnt);
        end
        // AlignStart lands in the SLIP cycle of the first new pulse (A+2).
        start_req = 1'b1;
        step();                       // A+2
        start_req = 1'b0;
        checks++;
        if (obs_slip !== 1'b1 || obs_cnt !== 4'd1) begin
            errors++;
            $display("FAIL restart_first_pulse: got slip=%b cnt=%0d expected slip=1 cnt=1", obs_slip, obs_cnt);
        end
        step();                       // A+3: pulse done, counters cleared
        checks++;
        if (obs_slip !== 1'b0 || obs_cnt !== 4'd0) begin
            errors++;
            $display("FAIL start_in_slip: got slip=%b cnt=%0d expected slip=0 cnt=0", obs_slip, obs_cnt);
        end
        step();                       // A+4: pulse from mismatch sampled at A+3
        checks++;
        if (obs_slip !== 1'b1 || obs_cnt !== 4'd1) begin
            errors++;
            $display("FAIL start_in_slip_next: got slip=%b cnt=%0d expected slip=1 cnt=1", obs_slip, obs_cnt);
        end
    endtask

    task automatic test_align_start_locked();
        do_reset();
        offset = 0;
        data_mode = DM_MODEL;
        run_align(0, cyc + 1, "start_lock_first");
        repeat ($urandom_range(2, 6)) step();
        start_req = 1'b1;
        step();                       // cycle A
        start_req = 1'b0;
        checks++;
        if (obs_done !== 1'b1) begin
            errors++;
            $display("FAIL start_locked_before: got done=%b expected 1", obs_done);
        end
        step();                       // A+1
        checks++;
        if (obs_done !== 1'b0 || obs_cnt !== 4'd0) begin
            errors++;
            $display("FAIL start_locked_clear: got done=%b cnt=%0d expected done=0 cnt=0", obs_done, obs_cnt);
        end
        run_align(0, cyc, "start_lock_again");
    endtask

    task automatic test_loss(input bit mism[$], input string tag);
        int lidx;
        int run;
        int stop;
        logic exp_done;
        do_reset();
        offset = 0;
        data_mode = DM_MODEL;
        run_align(0, cyc + 1, {tag, "_lock"});
        repeat ($urandom_range(1, 4)) step();
        lidx = -1;
        run = 0;
        for (int j = 0; j < mism.size(); j++) begin
            run = mism[j] ? run + 1 : 0;
            if (run >= LOSS && lidx < 0) lidx = j;
        end
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
        stop = lidx + 2;
`else
        stop = mism.size() - 1;
`endif
        data_mode = DM_FIXED;
        for (int j = 0; j <= stop; j++) begin
            drv_data = mism[j] ? noise_word() : PAT;
            step();
`ifdef ADC_FRAME_ALIGN_MONITOR_EN
            if (j <= lidx + 1) begin
                exp_done = (j <= lidx);
                checks++;
                if (obs_done !== exp_done || obs_slip !== 1'b0) begin
                    errors++;
                    $display("FAIL %s seq%0d: got done=%b slip=%b expected done=%b slip=0",
                             tag, j, obs_done, obs_slip, exp_done);
                end
            end
            if (j == lidx + 1) begin
                checks++;
                if (obs_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL %s unlock_slipcount: got %0d expected 0", tag, obs_cnt);
                end
            end
            if (j == lidx + 2) begin
                checks++;
                if (obs_slip !== logic'(mism[lidx + 1]) || obs_cnt !== 4'(mism[lidx + 1])) begin
                    errors++;
                    $display("FAIL %s realign_pulse: got slip=%b cnt=%0d expected slip=%0d cnt=%0d",
                             tag, obs_slip, obs_cnt, mism[lidx + 1], mism[lidx + 1]);
                end
            end
`else
            checks++;
            if (obs_done !== 1'b1 || obs_slip !== 1'b0) begin
                errors++;
                $display("FAIL %s sticky%0d: got done=%b slip=%b expected done=1 slip=0",
                         tag, j, obs_done, obs_slip);
            end
`endif
        end
    endtask

    task automatic test_loss_of_lock();
        bit plan[$];
        bit rnd[$];
        plan = '{1, 1, 1, 0, 1, 1, 1, 1};
        repeat (LOSS + 3) plan.push_back(1'b1);
        test_loss(plan, "loss_plan");
        repeat (20) rnd.push_back($urandom_range(0, 3) != 0);
        repeat (LOSS + 3) rnd.push_back(1'b1);
        test_loss(rnd, "loss_rand");
    endtask

    task automatic test_reset_mid();
        int s0;
        int r;
        int p;
        // Reset during WAIT after the third pulse.
        do_reset();
        offset = 6;
        data_mode = DM_MODEL;
        s0 = cyc + 1;
        r = s0 + 1 + 2 * (W + 2) + 2;
        while (cyc < r - 1) step();
        rst_n_req = 1'b0;
        step();                       // cycle r
        checks++;
        if (obs_cnt !== 4'd3 || obs_slip !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_pre: got cnt=%0d slip=%b expected cnt=3 slip=0", obs_cnt, obs_slip);
        end
        rst_n_req = 1'b1;
        step();                       // r+1
        checks++;
        if ({obs_slip, obs_done, obs_err, obs_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL rst_wait_clear: got slip=%b done=%b err=%b cnt=%0d expected all 0",
                     obs_slip, obs_done, obs_err, obs_cnt);
        end
        run_align(3, r + 1, "rst_wait_realign");

        // Reset during the SLIP cycle of the second pulse.
        do_reset();
        offset = 4;
        data_mode = DM_MODEL;
        s0 = cyc + 1;
        p = s0 + 1 + (W + 2);
        while (cyc < p - 1) step();
        rst_n_req = 1'b0;
        step();                       // cycle p
        checks++;
        if (obs_slip !== 1'b1 || obs_cnt !== 4'd2) begin
            errors++;
            $display("FAIL rst_slip_pre: got slip=%b cnt=%0d expected slip=1 cnt=2", obs_slip, obs_cnt);
        end
        rst_n_req = 1'b1;
        step();                       // p+1
        checks++;
        if ({obs_slip, obs_done, obs_err, obs_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL rst_slip_clear: got slip=%b done=%b err=%b cnt=%0d expected all 0",
                     obs_slip, obs_done, obs_err, obs_cnt);
        end
        run_align(2, p + 1, "rst_slip_realign");
    endtask

    initial begin
        test_reset();
        test_align();
        test_fail();
        test_align_start_locked();
        test_loss_of_lock();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_frame_align.md
# adc_frame_align

Frame-alignment controller for the ADC LVDS receive path. It watches the 14-bit deserialized frame-clock word and issues single-cycle bitslip pulses to the frame and data deserializers until the word equals the expected frame pattern. It then declares lock, which drives the data path's frame-align-done input, and optionally monitors for loss of lock. The block sits in the divided-clock domain between the frame-line deserializer and the data-line capture blocks.

## Interface
- FRAME_PATTERN, 14'b11111110000000, expected deserialized frame word when aligned
- SLIP_WAIT, 4, settle cycles after each bitslip before sampling resumes (1..15)
- MATCH_COUNT, 8, consecutive matches required to declare lock (1..255)
- LOSS_COUNT, 4, consecutive mismatches in lock that cause realignment (1..255)
- FrmClkDiv  in  1  divided frame clock; the only clock, all logic on its rising edge
- FrmRstN  in  1  reset; one clock, reset is synchronous and active-low
- FrmData  in  14  deserialized frame word, valid every cycle
- AlignStart  in  1  single-cycle request to restart alignment from slip position 0
- FrmBitslip  out  1  one-cycle bitslip pulse to all deserializers
- FrmAlignDone  out  1  high while locked
- FrmAlignErr  out  1  high after all 14 slip positions failed
- SlipCount  out  4  bitslips issued in the current attempt (0..13)

## Operation
- States: CHECK, SLIP, WAIT, LOCKED, FAIL. Reset enters CHECK with all counters at 0.
- CHECK: a cycle with FrmData == FRAME_PATTERN increments the match counter. When the counter reaches MATCH_COUNT, go to LOCKED.
- CHECK mismatch: clear the match counter. If SlipCount == 13, go to FAIL; otherwise go to SLIP.
- SLIP: lasts exactly 1 cycle; FrmBitslip = 1; SlipCount increments; go to WAIT.
- WAIT: ignore FrmData for SLIP_WAIT cycles, then go to CHECK.
- LOCKED: FrmAlignDone = 1. Loss-of-lock handling is described under Configuration.
- FAIL: FrmAlignErr = 1. No bitslips are issued. FAIL is left only by AlignStart or reset.
- AlignStart, from any state: go to CHECK and clear SlipCount, the match counter, the mismatch counter, FrmAlignDone and FrmAlignErr.
- Priority: reset > AlignStart > state logic. If AlignStart arrives during SLIP, the pulse already being driven completes and no further pulse follows.
- All outputs are registered and decoded from state and counters. Reset values: FrmBitslip = 0, FrmAlignDone = 0, FrmAlignErr = 0, SlipCount = 0.
- Counters saturate and never wrap. SlipCount never exceeds 13.

## Timing
- A mismatch sampled in CHECK at cycle N gives FrmBitslip high at N+1 only. WAIT covers N+2..N+1+SLIP_WAIT. Sampling resumes at N+2+SLIP_WAIT.
- SlipCount updates in the same cycle FrmBitslip is high.
- Lock latency: with the MATCH_COUNT-th consecutive match at cycle M, FrmAlignDone rises at M+1.
- FAIL: a mismatch at slip position 13 at cycle N gives FrmAlignErr high at N+1, with no pulse.
- Loss of lock: with the LOSS_COUNT-th consecutive mismatch at cycle L, FrmAlignDone falls at L+1. The first bitslip of the new attempt follows the rules for CHECK.
- AlignStart at cycle A: all outputs are cleared at A+1, and sampling in CHECK starts at A+1.
- Reset asserted mid-operation, including during SLIP: outputs are at reset values on the next edge.

## Configuration
- Macro ADC_FRAME_ALIGN_MONITOR_EN.
- Defined: in LOCKED, consecutive mismatches are counted and any match clears the count. Reaching LOSS_COUNT returns to CHECK with SlipCount cleared, FrmAlignDone falls, and alignment restarts.
- Undefined: LOCKED is sticky and FrmData is ignored. Only AlignStart or reset leaves LOCKED. The mismatch counter is not built.

## Test plan
- Frame model rotates the pattern by one bit per FrmBitslip, starting at offset 5 -> exactly 5 one-cycle pulses spaced SLIP_WAIT+2 cycles apart; SlipCount = 5; FrmAlignDone rises 9 cycles after the last WAIT ends (8 matches + 1); FrmAlignErr = 0.
- FrmData held at 14'h0000 -> 13 pulses, then FrmAlignErr = 1 with SlipCount = 13; no further pulses for 100 cycles; AlignStart clears FrmAlignErr and restarts at SlipCount = 0.
- Locked, monitor defined; 3 mismatches, 1 match, then 4 mismatches -> lock held through the first 3; FrmAlignDone falls one cycle after the 4th of the final run; realignment pulses resume.
- Same stimulus with the monitor undefined -> FrmAlignDone stays 1 and no pulses are issued.
- FrmRstN low for 1 cycle during WAIT at SlipCount = 3 -> all outputs 0 next cycle; alignment restarts from SlipCount = 0 with no stray pulse.
- AlignStart while locked at offset 0 -> FrmAlignDone falls at A+1 and rises again MATCH_COUNT+1 cycles later with zero pulses.
